// File: rtl/stdp_synapse.sv
// Pair-based nearest-neighbour STDP synapse with a linear timing window.
// Holds one plastic weight; per-side age counters measure pre/post spike spacing.
module stdp_synapse #(
    parameter int W_WIDTH    = 8,
    parameter int T_WIDTH    = 4,
    parameter int WINDOW     = 15,
    parameter int W_INIT     = 128,
    parameter int W_MAX      = 255,
    parameter int GAIN_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pre_spike,
    input  logic               post_spike,
    input  logic               learn_en,
    output logic [W_WIDTH-1:0] weight,
    output logic [T_WIDTH-1:0] time_diff,
    output logic               update_w_flag,
    output logic               ltp,
    output logic               ltd
);

    localparam int                 DW      = W_WIDTH + 2;
    localparam logic [T_WIDTH-1:0] AGE_WIN = T_WIDTH'(WINDOW);
    localparam logic [T_WIDTH-1:0] AGE_ONE = T_WIDTH'(1);

    logic [T_WIDTH-1:0] pre_age_q, pre_age_d;
    logic [T_WIDTH-1:0] post_age_q, post_age_d;
    logic [W_WIDTH-1:0] weight_q, weight_d;
    logic [T_WIDTH-1:0] time_diff_q, time_diff_d;
    logic               upd_q, upd_d;
    logic               ltp_q, ltp_d;
    logic               ltd_q, ltd_d;

    logic               pre_valid, post_valid;
    logic [DW-1:0]      delta_up, delta_dn;
    logic [DW-1:0]      sum_up, diff_dn;
    logic [W_WIDTH-1:0] w_up, w_dn;

    function automatic logic [T_WIDTH-1:0] age_next(input logic [T_WIDTH-1:0] a);
        return (a < AGE_WIN) ? a + AGE_ONE : AGE_WIN;
    endfunction

    // Full-width arithmetic so the saturation compare sees the true result.
    always_comb begin
        pre_valid  = pre_age_q < AGE_WIN;
        post_valid = post_age_q < AGE_WIN;
        delta_up   = (DW'(WINDOW) - DW'(pre_age_q)) << GAIN_SHIFT;
        delta_dn   = (DW'(WINDOW) - DW'(post_age_q)) << GAIN_SHIFT;
        sum_up     = DW'(weight_q) + delta_up;
        diff_dn    = DW'(weight_q) - delta_dn;
        w_up       = (sum_up > DW'(W_MAX)) ? W_WIDTH'(W_MAX) : sum_up[W_WIDTH-1:0];
        w_dn       = (delta_dn > DW'(weight_q)) ? '0 : diff_dn[W_WIDTH-1:0];
    end

    always_comb begin
        pre_age_d   = age_next(pre_age_q);
        post_age_d  = age_next(post_age_q);
        weight_d    = weight_q;
        time_diff_d = time_diff_q;
        upd_d       = 1'b0;
        ltp_d       = 1'b0;
        ltd_d       = 1'b0;
        case ({pre_spike, post_spike})
            2'b11: begin
                pre_age_d  = AGE_ONE;
                post_age_d = AGE_ONE;
            end
            2'b01: begin
                post_age_d = AGE_ONE;
                if (pre_valid) begin
                    pre_age_d = AGE_WIN;
                    if (learn_en) begin
                        weight_d    = w_up;
                        time_diff_d = pre_age_q;
                        upd_d       = 1'b1;
                        ltp_d       = 1'b1;
                    end
                end
            end
            2'b10: begin
                pre_age_d = AGE_ONE;
                if (post_valid) begin
                    post_age_d = AGE_WIN;
                    if (learn_en) begin
                        weight_d    = w_dn;
                        time_diff_d = post_age_q;
                        upd_d       = 1'b1;
                        ltd_d       = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_age_q   <= AGE_WIN;
            post_age_q  <= AGE_WIN;
            weight_q    <= W_WIDTH'(W_INIT);
            time_diff_q <= '0;
            upd_q       <= 1'b0;
            ltp_q       <= 1'b0;
            ltd_q       <= 1'b0;
        end else begin
            pre_age_q   <= pre_age_d;
            post_age_q  <= post_age_d;
            weight_q    <= weight_d;
            time_diff_q <= time_diff_d;
            upd_q       <= upd_d;
            ltp_q       <= ltp_d;
            ltd_q       <= ltd_d;
        end
    end

    assign weight        = weight_q;
    assign time_diff     = time_diff_q;
    assign update_w_flag = upd_q;
    assign ltp           = ltp_q;
    assign ltd           = ltd_q;

endmodule

// File: tb/tb_stdp_synapse.sv
// Directed bench for stdp_synapse: a vector table for the main pairing cases,
// then hand-written sequences for reset, saturation and floor behaviour.
module tb_stdp_synapse;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_spike, post_spike, learn_en;
    logic [7:0] weight;
    logic [3:0] time_diff;
    logic       update_w_flag, ltp, ltd;

    int unsigned checks = 0;
    int unsigned errors = 0;

    stdp_synapse #(
        .W_WIDTH(8), .T_WIDTH(4), .WINDOW(15),
        .W_INIT(128), .W_MAX(255), .GAIN_SHIFT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_spike(pre_spike), .post_spike(post_spike), .learn_en(learn_en),
        .weight(weight), .time_diff(time_diff),
        .update_w_flag(update_w_flag), .ltp(ltp), .ltd(ltd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned gap;
        logic        pre, post, learn;
        logic [7:0]  w;
        logic [3:0]  td;
        logic        upd, p, d;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] w, input logic [3:0] td,
                           input logic upd, input logic p, input logic d);
        chk({name, ".weight"}, 32'(weight), 32'(w));
        chk({name, ".time_diff"}, 32'(time_diff), 32'(td));
        chk({name, ".update_w_flag"}, 32'(update_w_flag), 32'(upd));
        chk({name, ".ltp"}, 32'(ltp), 32'(p));
        chk({name, ".ltd"}, 32'(ltd), 32'(d));
    endtask

    task automatic step(input logic pre, input logic post, input logic learn);
        @(negedge clk);
        pre_spike  = pre;
        post_spike = post;
        learn_en   = learn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] sat_exp[4];
        logic [7:0] flr_exp[4];

        rst_n      = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        learn_en   = 1'b1;

        //                gap pre post lrn  w   td upd ltp ltd
        vecs[0]  = '{9,  1'b1, 1'b0, 1'b1, 8'd128, 4'd0,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2,  1'b0, 1'b1, 1'b1, 8'd176, 4'd3,  1'b1, 1'b1, 1'b0};
        vecs[2]  = '{0,  1'b0, 1'b0, 1'b1, 8'd176, 4'd3,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16, 1'b0, 1'b1, 1'b1, 8'd176, 4'd3,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4,  1'b1, 1'b0, 1'b1, 8'd136, 4'd5,  1'b1, 1'b0, 1'b1};
        vecs[5]  = '{0,  1'b1, 1'b0, 1'b1, 8'd136, 4'd5,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16, 1'b1, 1'b0, 1'b1, 8'd136, 4'd5,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{14, 1'b0, 1'b1, 1'b1, 8'd136, 4'd5,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16, 1'b1, 1'b0, 1'b1, 8'd136, 4'd5,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{13, 1'b0, 1'b1, 1'b1, 8'd140, 4'd14, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{16, 1'b1, 1'b1, 1'b1, 8'd140, 4'd14, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1,  1'b0, 1'b1, 1'b1, 8'd192, 4'd2,  1'b1, 1'b1, 1'b0};
        vecs[12] = '{16, 1'b1, 1'b0, 1'b0, 8'd192, 4'd2,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1,  1'b0, 1'b1, 1'b0, 8'd192, 4'd2,  1'b0, 1'b0, 1'b0};
        vecs[14] = '{0,  1'b0, 1'b1, 1'b1, 8'd192, 4'd2,  1'b0, 1'b0, 1'b0};
        vecs[15] = '{4,  1'b1, 1'b0, 1'b1, 8'd152, 4'd5,  1'b1, 1'b0, 1'b1};
        vecs[16] = '{0,  1'b0, 1'b0, 1'b1, 8'd152, 4'd5,  1'b0, 1'b0, 1'b0};

        sat_exp = '{8'd184, 8'd240, 8'd255, 8'd255};
        flr_exp = '{8'd72, 8'd16, 8'd0, 8'd0};

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 8'd128, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 17; i++) begin
            idle(vecs[i].gap);
            step(vecs[i].pre, vecs[i].post, vecs[i].learn);
            chk_out($sformatf("vec%0d", i), vecs[i].w, vecs[i].td,
                    vecs[i].upd, vecs[i].p, vecs[i].d);
        end

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 8'd128, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset between a pre and its post discards the pending pre age.
        step(1'b1, 1'b0, 1'b1);
        idle(2);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        idle(1);
        step(1'b0, 1'b1, 1'b1);
        chk_out("midwin_reset", 8'd128, 4'd0, 1'b0, 1'b0, 1'b0);

        do_reset();
        for (int unsigned k = 0; k < 4; k++) begin
            idle(16);
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b1);
            chk_out($sformatf("sat%0d", k), sat_exp[k], 4'd1, 1'b1, 1'b1, 1'b0);
            idle(1);
            chk($sformatf("sat%0d.flag_drop", k), 32'(update_w_flag), 32'd0);
        end

        do_reset();
        for (int unsigned k = 0; k < 4; k++) begin
            idle(16);
            step(1'b0, 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b1);
            chk_out($sformatf("floor%0d", k), flr_exp[k], 4'd1, 1'b1, 1'b0, 1'b1);
            idle(1);
            chk($sformatf("floor%0d.flag_drop", k), 32'(ltd), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
